// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Purpose  : Multi-cycle IF/ID/EX/MEM/WB control sequencer with memory-ready
//            stalls, sticky HALT on illegal opcodes and a retired counter.
//            Optional MC_LOGIC_IMM_EN enables ANDI/ORI/XORI.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  alu_op,
  output logic        alu_src_b,
  output logic        ext_sign,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [1:0]  pc_src,
  output logic [2:0]  stage,
  output logic        halted,
  output logic        instr_done,
  output logic [31:0] retired
);

  localparam logic [2:0] c_ST_IF   = 3'd0;
  localparam logic [2:0] c_ST_ID   = 3'd1;
  localparam logic [2:0] c_ST_EX   = 3'd2;
  localparam logic [2:0] c_ST_MEM  = 3'd3;
  localparam logic [2:0] c_ST_WB   = 3'd4;
  localparam logic [2:0] c_ST_HALT = 3'd7;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [3:0] c_ALU_ADD = 4'd0;
  localparam logic [3:0] c_ALU_SUB = 4'd1;
  localparam logic [3:0] c_ALU_AND = 4'd2;
  localparam logic [3:0] c_ALU_OR  = 4'd3;
  localparam logic [3:0] c_ALU_XOR = 4'd4;
  localparam logic [3:0] c_ALU_SLT = 4'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_retired;

  logic       w_is_r, w_is_j, w_is_beq, w_is_bne, w_is_addi, w_is_lw, w_is_sw;
  logic       w_is_limm, w_r_legal, w_legal;
  logic [3:0] w_r_op, w_limm_op;

  assign w_is_r    = (opcode == c_OP_RTYPE);
  assign w_is_j    = (opcode == c_OP_J);
  assign w_is_beq  = (opcode == c_OP_BEQ);
  assign w_is_bne  = (opcode == c_OP_BNE);
  assign w_is_addi = (opcode == c_OP_ADDI);
  assign w_is_lw   = (opcode == c_OP_LW);
  assign w_is_sw   = (opcode == c_OP_SW);

`ifdef MC_LOGIC_IMM_EN
  localparam logic [5:0] c_OP_ANDI = 6'b001100;
  localparam logic [5:0] c_OP_ORI  = 6'b001101;
  localparam logic [5:0] c_OP_XORI = 6'b001110;

  assign w_is_limm = (opcode == c_OP_ANDI) || (opcode == c_OP_ORI) || (opcode == c_OP_XORI);
  assign w_limm_op = (opcode == c_OP_ANDI) ? c_ALU_AND :
                     (opcode == c_OP_ORI)  ? c_ALU_OR  : c_ALU_XOR;
`else
  assign w_is_limm = 1'b0;
  assign w_limm_op = c_ALU_ADD;
`endif

  always_comb begin
    w_r_legal = 1'b1;
    w_r_op    = c_ALU_ADD;
    case (funct)
      6'b100000: w_r_op = c_ALU_ADD;
      6'b100010: w_r_op = c_ALU_SUB;
      6'b100100: w_r_op = c_ALU_AND;
      6'b100101: w_r_op = c_ALU_OR;
      6'b100110: w_r_op = c_ALU_XOR;
      6'b101010: w_r_op = c_ALU_SLT;
      default:   w_r_legal = 1'b0;
    endcase
  end

  assign w_legal = w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_bne |
                   w_is_limm | (w_is_r & w_r_legal);

  always_comb begin
    w_next     = r_state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_op     = c_ALU_ADD;
    alu_src_b  = 1'b0;
    ext_sign   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'd0;
    halted     = 1'b0;
    instr_done = 1'b0;
    stage      = r_state;
    case (r_state)
      c_ST_IF: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = c_ST_ID;
        end
      end
      c_ST_ID: begin
        if (w_is_j) begin
          pc_we      = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          w_next     = c_ST_IF;
        end else if (w_legal) begin
          w_next = c_ST_EX;
        end else begin
          w_next = c_ST_HALT;
        end
      end
      c_ST_EX: begin
        if (w_is_r) begin
          alu_op = w_r_op;
          w_next = c_ST_WB;
        end else if (w_is_addi || w_is_lw || w_is_sw) begin
          alu_src_b = 1'b1;
          ext_sign  = 1'b1;
          w_next    = w_is_addi ? c_ST_WB : c_ST_MEM;
        end else if (w_is_beq || w_is_bne) begin
          alu_op     = c_ALU_SUB;
          ext_sign   = 1'b1;
          pc_src     = 2'd1;
          pc_we      = w_is_beq ? alu_zero : ~alu_zero;
          instr_done = 1'b1;
          w_next     = c_ST_IF;
        end else if (w_is_limm) begin
          alu_op    = w_limm_op;
          alu_src_b = 1'b1;
          w_next    = c_ST_WB;
        end else begin
          w_next = c_ST_HALT;
        end
      end
      c_ST_MEM: begin
        if (w_is_lw) begin
          mem_re = 1'b1;
          if (mem_ready) w_next = c_ST_WB;
        end else if (w_is_sw) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            w_next     = c_ST_IF;
          end
        end else begin
          w_next = c_ST_HALT;
        end
      end
      c_ST_WB: begin
        reg_we     = 1'b1;
        reg_dst    = w_is_r;
        mem_to_reg = w_is_lw;
        instr_done = 1'b1;
        w_next     = c_ST_IF;
      end
      c_ST_HALT: halted = 1'b1;
      default:   w_next = c_ST_HALT;
    endcase

    // Reset silences every control line, including an outstanding request.
    if (rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      alu_op     = c_ALU_ADD;
      alu_src_b  = 1'b0;
      ext_sign   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 2'd0;
      halted     = 1'b0;
      instr_done = 1'b0;
      stage      = c_ST_IF;
    end
  end

  assign retired = rst ? 32'd0 : r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_IF;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next;
      if (instr_done) r_retired <= r_retired + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Purpose  : Directed self-checking bench for mc_control_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  logic        clk, rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero, mem_ready;
  logic        pc_we, ir_we, reg_we, mem_re, mem_we;
  logic [3:0]  alu_op;
  logic        alu_src_b, ext_sign, reg_dst, mem_to_reg;
  logic [1:0]  pc_src;
  logic [2:0]  stage;
  logic        halted, instr_done;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ret = 32'd0;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .mem_re(mem_re), .mem_we(mem_we), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .ext_sign(ext_sign), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .stage(stage),
    .halted(halted), .instr_done(instr_done), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_ret = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b001000; funct = 6'd0; mem_ready = 1'b1; alu_zero = 1'b1;
    #1;
    n_tests++;
    if ({pc_we, ir_we, reg_we, mem_re, mem_we, instr_done, halted, stage, retired} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs pc_we=%b ir_we=%b mem_re=%b stage=%0d retired=%0d (want all 0)",
               pc_we, ir_we, mem_re, stage, retired);
    end
    next_cycle();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({stage, mem_re, ir_we, retired} !== {3'd0, 1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_release stage=%0d mem_re=%b ir_we=%b retired=%0d (want 0,1,0,0)",
               stage, mem_re, ir_we, retired);
    end
  endtask

  task automatic test_addi();
    opcode = 6'b001000; mem_ready = 1'b1; #1;
    n_tests++;
    if ({stage, ir_we, pc_we, pc_src} !== {3'd0, 1'b1, 1'b1, 2'd0}) begin
      n_fail++; $display("FAIL addi_if stage=%0d ir_we=%b pc_we=%b pc_src=%0d (want 0,1,1,0)", stage, ir_we, pc_we, pc_src);
    end
    next_cycle(); #1;
    n_tests++;
    if (stage !== 3'd1) begin n_fail++; $display("FAIL addi_id stage=%0d (want 1)", stage); end
    next_cycle(); #1;
    n_tests++;
    if ({stage, alu_op, alu_src_b, ext_sign} !== {3'd2, 4'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL addi_ex stage=%0d alu_op=%0d src_b=%b ext=%b (want 2,0,1,1)", stage, alu_op, alu_src_b, ext_sign);
    end
    next_cycle(); #1;
    n_tests++;
    if ({stage, reg_we, reg_dst, mem_to_reg, instr_done} !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL addi_wb stage=%0d reg_we=%b reg_dst=%b m2r=%b done=%b (want 4,1,0,0,1)", stage, reg_we, reg_dst, mem_to_reg, instr_done);
    end
    exp_ret = exp_ret + 1;
    next_cycle(); #1;
    n_tests++;
    if ({stage, retired} !== {3'd0, exp_ret}) begin
      n_fail++; $display("FAIL addi_retire stage=%0d retired=%0d (want 0,%0d)", stage, retired, exp_ret);
    end
  endtask

  task automatic test_rtype();
    opcode = 6'b000000; funct = 6'b100010; mem_ready = 1'b1; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    n_tests++;
    if ({stage, alu_op, alu_src_b} !== {3'd2, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL rtype_ex stage=%0d alu_op=%0d src_b=%b (want 2,1,0)", stage, alu_op, alu_src_b);
    end
    next_cycle(); #1;
    n_tests++;
    if ({stage, reg_we, reg_dst, mem_to_reg} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rtype_wb stage=%0d reg_we=%b reg_dst=%b m2r=%b (want 4,1,1,0)", stage, reg_we, reg_dst, mem_to_reg);
    end
    exp_ret = exp_ret + 1;
    next_cycle(); #1;
    n_tests++;
    if ({stage, retired} !== {3'd0, exp_ret}) begin
      n_fail++; $display("FAIL rtype_retire stage=%0d retired=%0d (want 0,%0d)", stage, retired, exp_ret);
    end
  endtask

  task automatic test_lw_stall();
    int cycles;
    cycles = 0;
    opcode = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0; #1;
      n_tests++;
      if ({stage, mem_re, ir_we, pc_we} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL lw_if_stall%0d stage=%0d mem_re=%b ir_we=%b (want 0,1,0)", i, stage, mem_re, ir_we);
      end
      next_cycle(); cycles++;
    end
    mem_ready = 1'b1; #1;
    n_tests++;
    if ({mem_re, ir_we} !== 2'b11) begin n_fail++; $display("FAIL lw_if_ready mem_re=%b ir_we=%b (want 1,1)", mem_re, ir_we); end
    next_cycle(); cycles++;
    mem_ready = 1'b0; next_cycle(); cycles++;
    next_cycle(); cycles++;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0; #1;
      n_tests++;
      if ({stage, mem_re, reg_we} !== {3'd3, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL lw_mem_stall%0d stage=%0d mem_re=%b reg_we=%b (want 3,1,0)", i, stage, mem_re, reg_we);
      end
      next_cycle(); cycles++;
    end
    mem_ready = 1'b1; #1;
    n_tests++;
    if ({stage, mem_re} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL lw_mem_ready stage=%0d mem_re=%b (want 3,1)", stage, mem_re); end
    next_cycle(); cycles++;
    #1;
    n_tests++;
    if ({stage, reg_we, mem_to_reg, reg_dst} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL lw_wb stage=%0d reg_we=%b m2r=%b reg_dst=%b (want 4,1,1,0)", stage, reg_we, mem_to_reg, reg_dst);
    end
    next_cycle(); cycles++;
    exp_ret = exp_ret + 1;
    #1;
    n_tests++;
    if ({stage, retired, cycles} !== {3'd0, exp_ret, 32'd10}) begin
      n_fail++; $display("FAIL lw_total stage=%0d retired=%0d cycles=%0d (want 0,%0d,10)", stage, retired, cycles, exp_ret);
    end
  endtask

  task automatic test_branch();
    logic exp_we;
    for (int i = 0; i < 4; i++) begin
      opcode   = (i < 2) ? 6'b000100 : 6'b000101;
      alu_zero = (i == 0 || i == 3);
      exp_we   = (i == 0 || i == 2);
      mem_ready = 1'b1; #1;
      next_cycle(); #1;
      next_cycle(); #1;
      n_tests++;
      if ({stage, pc_we, pc_src, alu_op, alu_src_b, instr_done} !== {3'd2, exp_we, 2'd1, 4'd1, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL branch%0d_ex stage=%0d pc_we=%b pc_src=%0d alu_op=%0d done=%b (want 2,%b,1,1,1)",
                           i, stage, pc_we, pc_src, alu_op, instr_done, exp_we);
      end
      exp_ret = exp_ret + 1;
      next_cycle(); #1;
      n_tests++;
      if ({stage, retired} !== {3'd0, exp_ret}) begin
        n_fail++; $display("FAIL branch%0d_retire stage=%0d retired=%0d (want 0,%0d)", i, stage, retired, exp_ret);
      end
    end
  endtask

  task automatic test_jump();
    opcode = 6'b000010; mem_ready = 1'b1; #1;
    next_cycle(); #1;
    n_tests++;
    if ({stage, pc_we, pc_src, instr_done} !== {3'd1, 1'b1, 2'd2, 1'b1}) begin
      n_fail++; $display("FAIL jump_id stage=%0d pc_we=%b pc_src=%0d done=%b (want 1,1,2,1)", stage, pc_we, pc_src, instr_done);
    end
    exp_ret = exp_ret + 1;
    next_cycle(); #1;
    n_tests++;
    if ({stage, retired} !== {3'd0, exp_ret}) begin
      n_fail++; $display("FAIL jump_retire stage=%0d retired=%0d (want 0,%0d)", stage, retired, exp_ret);
    end
  endtask

  task automatic test_ori();
    opcode = 6'b001101; funct = 6'd0; mem_ready = 1'b1; #1;
    next_cycle(); #1;
    next_cycle(); #1;
`ifdef MC_LOGIC_IMM_EN
    n_tests++;
    if ({stage, alu_op, ext_sign, alu_src_b} !== {3'd2, 4'd3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL ori_ex stage=%0d alu_op=%0d ext=%b src_b=%b (want 2,3,0,1)", stage, alu_op, ext_sign, alu_src_b);
    end
    next_cycle(); #1;
    n_tests++;
    if ({stage, reg_we, reg_dst} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ori_wb stage=%0d reg_we=%b reg_dst=%b (want 4,1,0)", stage, reg_we, reg_dst);
    end
    exp_ret = exp_ret + 1;
    next_cycle(); #1;
`else
    n_tests++;
    if ({stage, halted, retired} !== {3'd7, 1'b1, exp_ret}) begin
      n_fail++; $display("FAIL ori_halt stage=%0d halted=%b retired=%0d (want 7,1,%0d)", stage, halted, retired, exp_ret);
    end
    do_reset(); #1;
`endif
    n_tests++;
    if (stage !== 3'd0) begin n_fail++; $display("FAIL ori_after stage=%0d (want 0)", stage); end
  endtask

  task automatic test_illegal();
    opcode = 6'b000000; funct = 6'b000000; mem_ready = 1'b1; #1;
    next_cycle(); #1;
    n_tests++;
    if ({stage, pc_we, instr_done} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL illegal_id stage=%0d pc_we=%b done=%b (want 1,0,0)", stage, pc_we, instr_done);
    end
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; alu_zero = i[1]; #1;
      n_tests++;
      if ({stage, halted, pc_we, ir_we, reg_we, mem_re, mem_we, instr_done, retired} !== {3'd7, 1'b1, 6'd0, exp_ret}) begin
        n_fail++; $display("FAIL halt_hold%0d stage=%0d halted=%b pc_we=%b ir_we=%b reg_we=%b mem_re=%b mem_we=%b retired=%0d",
                           i, stage, halted, pc_we, ir_we, reg_we, mem_re, mem_we, retired);
      end
      next_cycle();
    end
    do_reset(); #1;
    n_tests++;
    if ({stage, halted, mem_re, retired} !== {3'd0, 1'b0, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL halt_recover stage=%0d halted=%b mem_re=%b retired=%0d (want 0,0,1,0)", stage, halted, mem_re, retired);
    end
    opcode = 6'b111111; mem_ready = 1'b1; #1;
    next_cycle(); next_cycle(); #1;
    n_tests++;
    if ({stage, halted} !== {3'd7, 1'b1}) begin
      n_fail++; $display("FAIL op3f_halt stage=%0d halted=%b (want 7,1)", stage, halted);
    end
    do_reset();
  endtask

  task automatic test_sw_reset();
    opcode = 6'b101011; funct = 6'd0; mem_ready = 1'b1; #1;
    next_cycle(); next_cycle(); #1;
    n_tests++;
    if ({stage, alu_src_b, ext_sign} !== {3'd2, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sw_ex stage=%0d src_b=%b ext=%b (want 2,1,1)", stage, alu_src_b, ext_sign);
    end
    next_cycle();
    mem_ready = 1'b0; #1;
    n_tests++;
    if ({stage, mem_we, instr_done} !== {3'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sw_mem_stall stage=%0d mem_we=%b done=%b (want 3,1,0)", stage, mem_we, instr_done);
    end
    next_cycle();
    rst = 1'b1; #1;
    n_tests++;
    if ({mem_we, mem_re, instr_done, retired} !== 35'd0) begin
      n_fail++; $display("FAIL sw_rst_drop mem_we=%b mem_re=%b done=%b retired=%0d (want 0,0,0,0)", mem_we, mem_re, instr_done, retired);
    end
    next_cycle();
    rst = 1'b0; mem_ready = 1'b0; exp_ret = 32'd0; #1;
    n_tests++;
    if ({stage, mem_re, mem_we, retired} !== {3'd0, 1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL sw_rst_release stage=%0d mem_re=%b mem_we=%b retired=%0d (want 0,1,0,0)", stage, mem_re, mem_we, retired);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    next_cycle();
    test_reset();
    test_addi();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_jump();
    test_ori();
    test_illegal();
    test_sw_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
